// File: rtl/axil_wr_arbiter.sv
// ----------------------------------------------------------------------------
// axil_wr_arbiter
//
// Round-robin arbiter for the write side (AW/W/B) of one AXI-Lite slave port.
// Exactly one master holds the grant from its first request until the B
// handshake (or a watchdog timeout) ends the transaction. The grant outputs
// drive the interconnect's write mux/demux selects. They are registered, so
// there is no combinational path from req to grant.
//
// Ports
//   aclk         in   clock, rising edge
//   aresetn      in   asynchronous active-low reset
//   req          in   [NUMBER_MASTER] per-master awvalid decoded to this slave
//   aw_hs        in   slave-side AW handshake this cycle
//   w_hs         in   slave-side W handshake this cycle
//   b_hs         in   slave-side B handshake (granted master) this cycle
//   grant        out  [NUMBER_MASTER] one-hot grant, zero when idle
//   grant_idx    out  [IDX_W] binary index of the granted master
//   grant_vld    out  a grant is active
//   timeout_err  out  one-cycle pulse when the watchdog forces a release
// ----------------------------------------------------------------------------
module axil_wr_arbiter #(
    parameter  int NUMBER_MASTER  = 2,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int IDX_W          = $clog2(NUMBER_MASTER)
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NUMBER_MASTER-1:0] req,
    input  logic                     aw_hs,
    input  logic                     w_hs,
    input  logic                     b_hs,
    output logic [NUMBER_MASTER-1:0] grant,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     grant_vld,
    output logic                     timeout_err
);

    // wd_cnt never exceeds TIMEOUT_CYCLES-1, so this width is sufficient
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ADDR_DATA = 2'd1,
        S_WAIT_B    = 2'd2
    } state_t;

    state_t                   r_state;
    logic [IDX_W-1:0]         r_rr_ptr;
    logic [WD_W-1:0]          r_wd_cnt;
    logic                     r_aw_done;
    logic                     r_w_done;
    logic [NUMBER_MASTER-1:0] r_grant;
    logic [IDX_W-1:0]         r_grant_idx;
    logic                     r_grant_vld;
    logic                     r_timeout_err;

    state_t                   w_state_next;
    logic [IDX_W-1:0]         w_rr_ptr_next;
    logic [WD_W-1:0]          w_wd_cnt_next;
    logic                     w_aw_done_next;
    logic                     w_w_done_next;
    logic [NUMBER_MASTER-1:0] w_grant_next;
    logic [IDX_W-1:0]         w_grant_idx_next;
    logic                     w_grant_vld_next;
    logic                     w_timeout_err_next;

    logic [IDX_W-1:0]         w_cand_idx [NUMBER_MASTER];
    logic                     w_pick_vld;
    logic [IDX_W-1:0]         w_pick_idx;
    logic                     w_b_done;
    logic                     w_timeout;
    logic                     w_release;
    logic [IDX_W-1:0]         w_rr_inc;

    // Candidate k in the search order is (rr_ptr + k) mod NUMBER_MASTER.
    // The sum is one bit wider than the index so the wrap is computed
    // correctly for non-power-of-two master counts.
    generate
        for (genvar gi = 0; gi < NUMBER_MASTER; gi++) begin : g_cand
            logic [IDX_W:0] w_sum;
            assign w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(gi);
            assign w_cand_idx[gi] = (w_sum >= (IDX_W+1)'(NUMBER_MASTER))
                                  ? IDX_W'(w_sum - (IDX_W+1)'(NUMBER_MASTER))
                                  : IDX_W'(w_sum);
        end
    endgenerate

    // Scan from the last candidate to the first so the lowest search offset
    // (closest to rr_ptr) is the one that sticks.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        for (int k = NUMBER_MASTER - 1; k >= 0; k--) begin
            if (req[w_cand_idx[k]]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_cand_idx[k];
            end
        end
    end

    // b_hs only counts once both AW and W are done; earlier it is ignored.
    assign w_b_done  = (r_state == S_WAIT_B) && b_hs;
    assign w_timeout = r_grant_vld && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign w_release = w_b_done || w_timeout;
    assign w_rr_inc  = (r_grant_idx == IDX_W'(NUMBER_MASTER - 1))
                     ? '0 : r_grant_idx + 1'b1;

    // Next-state and registered-output logic
    always_comb begin
        w_state_next       = r_state;
        w_rr_ptr_next      = r_rr_ptr;
        w_wd_cnt_next      = r_grant_vld ? r_wd_cnt + 1'b1 : r_wd_cnt;
        w_aw_done_next     = r_aw_done;
        w_w_done_next      = r_w_done;
        w_grant_next       = r_grant;
        w_grant_idx_next   = r_grant_idx;
        w_grant_vld_next   = r_grant_vld;
        w_timeout_err_next = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_grant_next     = NUMBER_MASTER'(1) << w_pick_idx;
                    w_grant_idx_next = w_pick_idx;
                    w_grant_vld_next = 1'b1;
                    w_wd_cnt_next    = '0;
                    w_state_next     = S_ADDR_DATA;
                end
            end
            S_ADDR_DATA: begin
                // Include this cycle's handshakes so AW and W can land together
                w_aw_done_next = r_aw_done | aw_hs;
                w_w_done_next  = r_w_done | w_hs;
                if (w_aw_done_next && w_w_done_next) begin
                    w_state_next = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                // Waiting for b_hs; release is handled below
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // A B handshake and a watchdog expiry release identically; a B
        // handshake in the expiry cycle wins and suppresses the error pulse.
        if (w_release) begin
            w_state_next       = S_IDLE;
            w_grant_next       = '0;
            w_grant_vld_next   = 1'b0;
            w_rr_ptr_next      = w_rr_inc;
            w_aw_done_next     = 1'b0;
            w_w_done_next      = 1'b0;
            w_wd_cnt_next      = '0;
            w_timeout_err_next = !w_b_done;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_wd_cnt      <= '0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_vld   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_rr_ptr      <= w_rr_ptr_next;
            r_wd_cnt      <= w_wd_cnt_next;
            r_aw_done     <= w_aw_done_next;
            r_w_done      <= w_w_done_next;
            r_grant       <= w_grant_next;
            r_grant_idx   <= w_grant_idx_next;
            r_grant_vld   <= w_grant_vld_next;
            r_timeout_err <= w_timeout_err_next;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_vld   = r_grant_vld;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_axil_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axil_wr_arbiter
//
// Directed bench for axil_wr_arbiter. Two instances share one clock:
//   u_dut2: 2 masters, 8-cycle watchdog
//   u_dut4: 4 masters, 8-cycle watchdog
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// at that same point, so the value seen after edge n is the "cycle n" value.
// ----------------------------------------------------------------------------
module tb_axil_wr_arbiter;

    logic       clk = 1'b0;
    logic       aresetn;

    logic [1:0] req2;
    logic       aw2, w2, b2;
    logic [1:0] g2;
    logic [0:0] gi2;
    logic       gv2, te2;

    logic [3:0] req4;
    logic       aw4, w4, b4;
    logic [3:0] g4;
    logic [1:0] gi4;
    logic       gv4, te4;

    int checks = 0;
    int errors = 0;
    int exp_idx;

    always #5 clk = ~clk;

    axil_wr_arbiter #(.NUMBER_MASTER(2), .TIMEOUT_CYCLES(8)) u_dut2 (
        .aclk        (clk),
        .aresetn     (aresetn),
        .req         (req2),
        .aw_hs       (aw2),
        .w_hs        (w2),
        .b_hs        (b2),
        .grant       (g2),
        .grant_idx   (gi2),
        .grant_vld   (gv2),
        .timeout_err (te2)
    );

    axil_wr_arbiter #(.NUMBER_MASTER(4), .TIMEOUT_CYCLES(8)) u_dut4 (
        .aclk        (clk),
        .aresetn     (aresetn),
        .req         (req4),
        .aw_hs       (aw4),
        .w_hs        (w4),
        .b_hs        (b4),
        .grant       (g4),
        .grant_idx   (gi4),
        .grant_vld   (gv4),
        .timeout_err (te4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // AW+W in the current cycle, then B in the next; ends in the idle cycle
    task automatic complete4();
        aw4 = 1'b1; w4 = 1'b1;
        step();
        aw4 = 1'b0; w4 = 1'b0; b4 = 1'b1;
        step();
        b4 = 1'b0;
        chk("d4_release_vld", 32'(gv4), 32'd0);
    endtask

    initial begin
        aresetn = 1'b0;
        req2 = '0; aw2 = 1'b0; w2 = 1'b0; b2 = 1'b0;
        req4 = '0; aw4 = 1'b0; w4 = 1'b0; b4 = 1'b0;
        step();
        step();

        // Reset values
        chk("rst_grant",   32'(g2),  32'd0);
        chk("rst_idx",     32'(gi2), 32'd0);
        chk("rst_vld",     32'(gv2), 32'd0);
        chk("rst_terr",    32'(te2), 32'd0);
        chk("rst_grant4",  32'(g4),  32'd0);
        chk("rst_vld4",    32'(gv4), 32'd0);
        aresetn = 1'b1;

        // T1: req=01 at c0 -> grant c1; aw c2, w c3, b c5 -> grant drops c6
        req2 = 2'b01;
        step();                                     // c1
        chk("t1_grant_c1", 32'(g2),  32'h1);
        chk("t1_idx_c1",   32'(gi2), 32'd0);
        chk("t1_vld_c1",   32'(gv2), 32'd1);
        req2 = 2'b00;
        step(); aw2 = 1'b1;                         // c2
        step(); aw2 = 1'b0; w2 = 1'b1;              // c3
        step(); w2 = 1'b0;                          // c4
        step();                                     // c5
        chk("t1_hold_c5",  32'(gv2), 32'd1);
        b2 = 1'b1;
        step(); b2 = 1'b0;                          // c6
        chk("t1_grant_c6", 32'(g2),  32'h0);
        chk("t1_vld_c6",   32'(gv2), 32'd0);
        chk("t1_terr_c6",  32'(te2), 32'd0);

        // T2: req=11 held; rr_ptr=1 so grants go 1,0,1,0 with one idle cycle each
        req2 = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_idx = (i % 2 == 0) ? 1 : 0;
            step();
            chk("t2_alt_idx",   32'(gi2), 32'(exp_idx));
            chk("t2_alt_grant", 32'(g2),  32'd1 << exp_idx);
            aw2 = 1'b1; w2 = 1'b1;
            step();
            aw2 = 1'b0; w2 = 1'b0; b2 = 1'b1;
            step();
            b2 = 1'b0;
            chk("t2_idle_grant", 32'(g2),  32'h0);
            chk("t2_idle_vld",   32'(gv2), 32'd0);
            if (i == 3) req2 = 2'b00;
        end

        // T3: rr_ptr=1; w c2, b c3 (ignored), aw c4, b c6 -> drop c7
        req2 = 2'b10;
        step();                                     // c1
        chk("t3_idx_c1",   32'(gi2), 32'd1);
        req2 = 2'b00;
        step(); w2 = 1'b1;                          // c2
        step(); w2 = 1'b0; b2 = 1'b1;               // c3
        step(); b2 = 1'b0;                          // c4
        chk("t3_b_ignored", 32'(gv2), 32'd1);
        aw2 = 1'b1;
        step(); aw2 = 1'b0;                         // c5
        step();                                     // c6
        chk("t3_hold_c6",  32'(gv2), 32'd1);
        b2 = 1'b1;
        step(); b2 = 1'b0;                          // c7
        chk("t3_drop_c7",  32'(gv2), 32'd0);

        // T4: rr_ptr=0, req=11, no handshakes -> watchdog release at c9,
        // master 1 granted at c10
        req2 = 2'b11;
        step();                                     // c1
        chk("t4_idx_c1",   32'(gi2), 32'd0);
        for (int c = 2; c <= 8; c++) begin
            step();
            chk("t4_wait_terr", 32'(te2), 32'd0);
            chk("t4_wait_vld",  32'(gv2), 32'd1);
        end
        step();                                     // c9
        chk("t4_to_grant", 32'(g2),  32'h0);
        chk("t4_to_terr",  32'(te2), 32'd1);
        step();                                     // c10
        chk("t4_next_grant", 32'(g2),  32'h2);
        chk("t4_next_idx",   32'(gi2), 32'd1);
        chk("t4_terr_pulse", 32'(te2), 32'd0);
        req2 = 2'b00;
        aw2 = 1'b1; w2 = 1'b1;
        step(); aw2 = 1'b0; w2 = 1'b0; b2 = 1'b1;
        step(); b2 = 1'b0;
        chk("t4_done_vld", 32'(gv2), 32'd0);

        // T5: b_hs in the watchdog expiry cycle -> normal release, no error
        req2 = 2'b01;
        step();                                     // c1
        chk("t5_idx_c1",   32'(gi2), 32'd0);
        req2 = 2'b00;
        aw2 = 1'b1; w2 = 1'b1;
        step();                                     // c2
        aw2 = 1'b0; w2 = 1'b0;
        for (int c = 3; c <= 8; c++) step();        // c8
        chk("t5_vld_c8",   32'(gv2), 32'd1);
        b2 = 1'b1;
        step(); b2 = 1'b0;                          // c9
        chk("t5_vld_c9",   32'(gv2), 32'd0);
        chk("t5_terr_c9",  32'(te2), 32'd0);

        // T6: reset while in WAIT_B (rr_ptr=1, master 1 granted)
        req2 = 2'b10;
        step();                                     // c1
        chk("t6_idx_c1",   32'(gi2), 32'd1);
        req2 = 2'b00;
        aw2 = 1'b1; w2 = 1'b1;
        step();                                     // c2, WAIT_B
        aw2 = 1'b0; w2 = 1'b0;
        chk("t6_vld_waitb", 32'(gv2), 32'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("t6_async_grant", 32'(g2),  32'h0);
        chk("t6_async_vld",   32'(gv2), 32'd0);
        chk("t6_async_terr",  32'(te2), 32'd0);
        step();
        chk("t6_rst_terr",    32'(te2), 32'd0);
        aresetn = 1'b1;
        req2 = 2'b11;
        step();
        chk("t6_rr_reset_idx",   32'(gi2), 32'd0);
        chk("t6_rr_reset_grant", 32'(g2),  32'h1);
        req2 = 2'b00;
        aw2 = 1'b1; w2 = 1'b1;
        step(); aw2 = 1'b0; w2 = 1'b0; b2 = 1'b1;
        step(); b2 = 1'b0;
        chk("t6_done_vld", 32'(gv2), 32'd0);

        // T7: four masters; move rr_ptr to 3, then check the wrap
        req4 = 4'b0100;
        step();
        chk("t7_idx2", 32'(gi4), 32'd2);
        req4 = 4'b0000;
        complete4();                                // rr_ptr=3
        req4 = 4'b1001;
        step();
        chk("t7_idx3",   32'(gi4), 32'd3);
        chk("t7_grant3", 32'(g4),  32'h8);
        req4 = 4'b0000;
        complete4();                                // rr_ptr=0
        req4 = 4'b1001;
        step();
        chk("t7_wrap_idx0",   32'(gi4), 32'd0);
        chk("t7_wrap_grant0", 32'(g4),  32'h1);
        req4 = 4'b0000;
        complete4();                                // rr_ptr=1
        req4 = 4'b1001;
        step();
        chk("t7_skip_idx3", 32'(gi4), 32'd3);
        req4 = 4'b0000;
        complete4();
        chk("t7_terr", 32'(te4), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
